// File: rtl/core_sync_mem_bridge.sv
// Word-organised synchronous RAM slave for the core request/response bus.
// Each request walks IDLE -> WAIT -> ACCESS -> RESP; responses are registered one-cycle pulses.
module core_sync_mem_bridge #(
  parameter int          MEMORY_SIZE  = 4096,
  parameter string       MEMORY_FILE  = "",
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] BASE_ADDRESS = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rw_address,
  input  logic        read_request,
  output logic [31:0] read_data,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic        access_fault,
  output logic        busy
);

  localparam int WORDS = MEMORY_SIZE / 4;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strobe_q;
  logic        is_read;
  logic        is_write;

  logic [31:0] offset;
  logic        in_range;
  logic [IW-1:0] index;

  logic [31:0] mem [WORDS];

  assign offset   = addr_q - BASE_ADDRESS;
  assign in_range = offset < 32'(MEMORY_SIZE);
  assign index    = offset[IW+1:2];

  // busy also covers the response cycle so a transaction reads as 3+WAIT_STATES busy cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= 4'd0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      strobe_q       <= 4'd0;
      is_read        <= 1'b0;
      is_write       <= 1'b0;
      read_data      <= 32'd0;
      read_response  <= 1'b0;
      write_response <= 1'b0;
      access_fault   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      read_response  <= 1'b0;
      write_response <= 1'b0;
      case (state)
        IDLE: begin
          if (read_request || write_request) begin
            addr_q   <= rw_address;
            wdata_q  <= write_data;
            strobe_q <= write_strobe;
            is_read  <= read_request;
            is_write <= write_request;
            busy     <= 1'b1;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              count <= WAIT_INIT;
            end else begin
              state <= ACCESS;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        WAIT: begin
          if (count == 4'd0) state <= ACCESS;
          else count <= count - 4'd1;
        end
        ACCESS: begin
          if (is_read) read_data <= in_range ? mem[index] : 32'd0;
          if (!in_range) access_fault <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          read_response  <= is_read;
          write_response <= is_write;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM has no reset; a reset forces IDLE, so an aborted write never reaches this block
  always_ff @(posedge clk) begin
    if (state == ACCESS && is_write && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe_q[b]) mem[index][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_core_sync_mem_bridge.sv
// Self-checking bench for core_sync_mem_bridge: directed vector table, reset abort
// sequence, and randomized traffic against a word-array reference model.
module tb_core_sync_mem_bridge;

  localparam int          WS   = 3;
  localparam int          LAT  = WS + 3;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] rw_address;
  logic        read_request;
  logic [31:0] read_data;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;
  logic        access_fault;
  logic        busy;

  int checks = 0;
  int errors = 0;

  core_sync_mem_bridge #(
    .MEMORY_SIZE(4096),
    .MEMORY_FILE(""),
    .WAIT_STATES(WS),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rw_address(rw_address),
    .read_request(read_request),
    .read_data(read_data),
    .read_response(read_response),
    .write_data(write_data),
    .write_strobe(write_strobe),
    .write_request(write_request),
    .write_response(write_response),
    .access_fault(access_fault),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One transaction: drive, capture, then watch a bounded window for responses and busy.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input bit toggle,
                        input logic [31:0] exp_data, input bit exp_fault);
    int rlat, wlat, rcnt, wcnt, bcnt;
    logic [31:0] rval;
    rlat = 0; wlat = 0; rcnt = 0; wcnt = 0; bcnt = 0; rval = 32'd0;
    @(negedge clk);
    rw_address = addr; write_data = data; write_strobe = strb;
    read_request = rd; write_request = wr;
    @(posedge clk);
    for (int j = 1; j <= LAT + 2; j++) begin
      @(negedge clk);
      if (read_response) begin
        rcnt++;
        if (rlat == 0) begin rlat = j; rval = read_data; end
      end
      if (write_response) begin
        wcnt++;
        if (wlat == 0) wlat = j;
      end
      if (busy) bcnt++;
      if (toggle && j <= WS) begin
        read_request  = 1'($urandom);
        write_request = 1'($urandom);
        rw_address    = $urandom;
        write_data    = $urandom;
        write_strobe  = 4'($urandom);
      end else begin
        read_request  = 1'b0;
        write_request = 1'b0;
      end
    end
    check("read_resp_count", 32'(rcnt), rd ? 32'd1 : 32'd0);
    check("write_resp_count", 32'(wcnt), wr ? 32'd1 : 32'd0);
    if (rd) begin
      check("read_latency", 32'(rlat), 32'(LAT));
      check("read_data_at_resp", rval, exp_data);
    end
    if (wr) check("write_latency", 32'(wlat), 32'(LAT));
    check("busy_cycles", 32'(bcnt), 32'(LAT));
    check("read_data_hold", read_data, exp_data);
    check("access_fault", 32'(access_fault), 32'(exp_fault));
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] off;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          toggle;
    logic [31:0] exp_data;
    bit          exp_fault;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] model_mem [16];
  logic [31:0] last_rdata;
  bit          model_fault;

  initial begin
    reset = 1'b0; rw_address = 32'd0; read_request = 1'b0; write_request = 1'b0;
    write_data = 32'd0; write_strobe = 4'd0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, busy, read_response, write_response, access_fault, 1'b0}, 32'd0);
    check("reset_read_data", read_data, 32'd0);
    reset = 1'b1;

    vecs.push_back('{0, 1, 32'h010, 32'hCAFEBABE, 4'hF, 0, 32'h00000000, 0});
    vecs.push_back('{1, 0, 32'h010, 32'h0,        4'h0, 0, 32'hCAFEBABE, 0});
    vecs.push_back('{0, 1, 32'h010, 32'h00000000, 4'h0, 0, 32'hCAFEBABE, 0});
    vecs.push_back('{1, 0, 32'h012, 32'h0,        4'h0, 0, 32'hCAFEBABE, 0});
    vecs.push_back('{0, 1, 32'h020, 32'h11223344, 4'hF, 0, 32'hCAFEBABE, 0});
    vecs.push_back('{0, 1, 32'h020, 32'hAABBCCDD, 4'h5, 0, 32'hCAFEBABE, 0});
    vecs.push_back('{1, 0, 32'h020, 32'h0,        4'h0, 0, 32'h11BB33DD, 0});
    vecs.push_back('{0, 1, 32'h030, 32'h00000005, 4'hF, 0, 32'h11BB33DD, 0});
    vecs.push_back('{1, 1, 32'h030, 32'h00000009, 4'hF, 0, 32'h00000005, 0});
    vecs.push_back('{1, 0, 32'h030, 32'h0,        4'h0, 0, 32'h00000009, 0});
    vecs.push_back('{0, 1, 32'hFFC, 32'h12345678, 4'hF, 0, 32'h00000009, 0});
    vecs.push_back('{0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 32'h00000009, 1});
    vecs.push_back('{1, 0, 32'h1000, 32'h0,       4'h0, 0, 32'h00000000, 1});
    vecs.push_back('{1, 0, 32'hFFC, 32'h0,        4'h0, 0, 32'h12345678, 1});
    vecs.push_back('{1, 0, 32'h010, 32'h0,        4'h0, 1, 32'hCAFEBABE, 1});
    vecs.push_back('{1, 0, 32'h010, 32'h0,        4'h0, 0, 32'hCAFEBABE, 1});
    vecs.push_back('{1, 0, 32'h020, 32'h0,        4'h0, 0, 32'h11BB33DD, 1});

    foreach (vecs[i])
      do_txn(vecs[i].rd, vecs[i].wr, BASE + vecs[i].off, vecs[i].data, vecs[i].strb,
             vecs[i].toggle, vecs[i].exp_data, vecs[i].exp_fault);

    // Reset asserted while a write to 0x40 sits in WAIT.
    do_txn(0, 1, BASE + 32'h40, 32'h0BADF00D, 4'hF, 0, 32'h11BB33DD, 1);
    @(negedge clk);
    rw_address = BASE + 32'h40; write_data = 32'hDEADBEEF; write_strobe = 4'hF;
    write_request = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write_request = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {27'd0, busy, read_response, write_response, access_fault, 1'b0}, 32'd0);
    check("mid_reset_read_data", read_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    begin
      int late = 0;
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        if (read_response || write_response || busy) late++;
      end
      check("no_resp_after_reset", 32'(late), 32'd0);
    end
    do_txn(1, 0, BASE + 32'h40, 32'h0, 4'h0, 0, 32'h0BADF00D, 0);

    // Randomized traffic against the word-array model.
    last_rdata  = 32'h0BADF00D;
    model_fault = 1'b0;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      do_txn(0, 1, BASE + 32'h100 + 32'(4 * i), model_mem[i], 4'hF, 0, last_rdata, 0);
    end
    for (int n = 0; n < 60; n++) begin
      bit          oor, rd, wr;
      int          idx, op;
      logic [31:0] off, data, exp;
      logic [3:0]  strb;
      oor  = ($urandom_range(0, 9) == 0);
      op   = $urandom_range(1, 3);
      rd   = op[0];
      wr   = op[1];
      idx  = $urandom_range(0, 15);
      data = $urandom;
      strb = 4'($urandom);
      if (oor) begin
        off = $urandom;
        if (off < 32'd4096) off = off + 32'd4096;
      end else begin
        off = 32'h100 + 32'(4 * idx) + 32'($urandom_range(0, 3));
      end
      exp = last_rdata;
      if (rd) exp = oor ? 32'd0 : model_mem[idx];
      if (wr && !oor)
        for (int b = 0; b < 4; b++)
          if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
      if (oor) model_fault = 1'b1;
      last_rdata = exp;
      do_txn(rd, wr, BASE + off, data, strb, 0, exp, model_fault);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
